// File: rtl/adder_pkg.sv
// Shared definitions for the adder result accumulator: sum width and frame FSM states.
package adder_pkg;

    localparam int SUM_W = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/sat_add.sv
// Combinational saturating add of a signed adder result onto a signed accumulator.
module sat_add
    import adder_pkg::*;
#(
    parameter int ACC_W = 6
) (
    input  logic [ACC_W-1:0] a,
    input  logic [SUM_W-1:0] b,
    output logic [ACC_W-1:0] sum,
    output logic             clamp
);

    logic [ACC_W:0] wide_s;

    // One guard bit is enough: an ACC_W-bit plus a narrower operand fits in ACC_W+1 bits.
    assign wide_s = $signed({a[ACC_W-1], a}) + $signed((ACC_W + 1)'($signed(b)));

    // Guard bit disagreeing with the sign bit means the true result left the ACC_W range.
    always_comb begin
        clamp = 1'b0;
        sum   = wide_s[ACC_W-1:0];
        if (wide_s[ACC_W] != wide_s[ACC_W-1]) begin
            clamp = 1'b1;
            if (wide_s[ACC_W] == 1'b0) begin
                sum = {1'b0, {(ACC_W - 1){1'b1}}};
            end else begin
                sum = {1'b1, {(ACC_W - 1){1'b0}}};
            end
        end else begin
            clamp = 1'b0;
        end
    end

endmodule

// File: rtl/sum_accumulator.sv
// Accumulates COUNT signed adder results per frame with saturation, a sticky
// saturation flag and an overflow tally, then holds the result until taken.
module sum_accumulator
    import adder_pkg::*;
#(
    parameter int COUNT = 4,
    parameter int ACC_W = 6
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [SUM_W-1:0]           sum_in,
    input  logic                       ovf_in,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [ACC_W-1:0]           acc_out,
    output logic                       sat_out,
    output logic [$clog2(COUNT+1)-1:0] ovf_count
);

    localparam int CNT_W = $clog2(COUNT + 1);

    state_t           state_r;
    state_t           next_state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_next_s;
    logic [ACC_W-1:0] acc_next_s;
    logic             sat_next_s;
    logic [CNT_W-1:0] ovf_next_s;
    logic [ACC_W-1:0] sat_sum_s;
    logic             clamp_s;
    logic             accept_s;
    logic             release_s;

    sat_add #(
        .ACC_W (ACC_W)
    ) u_sat_add (
        .a     (acc_out),
        .b     (sum_in),
        .sum   (sat_sum_s),
        .clamp (clamp_s)
    );

    assign in_ready  = (state_r != HOLD);
    assign accept_s  = in_valid && in_ready;
    assign release_s = (state_r == HOLD) && out_ready;

    // Next-state and next-datapath values; the handshake cycle clears the frame.
    always_comb begin
        next_state_s = state_r;
        cnt_next_s   = cnt_r;
        acc_next_s   = acc_out;
        sat_next_s   = sat_out;
        ovf_next_s   = ovf_count;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    next_state_s = ACCUM;
                end else begin
                    next_state_s = IDLE;
                end
            end
            ACCUM: begin
                if (accept_s && (cnt_r == CNT_W'(COUNT - 1))) begin
                    next_state_s = HOLD;
                end else begin
                    next_state_s = ACCUM;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = HOLD;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
        if (accept_s) begin
            acc_next_s = sat_sum_s;
            sat_next_s = sat_out | clamp_s;
            ovf_next_s = ovf_count + CNT_W'(ovf_in);
            cnt_next_s = cnt_r + CNT_W'(1);
        end else if (release_s) begin
            acc_next_s = {ACC_W{1'b0}};
            sat_next_s = 1'b0;
            ovf_next_s = {CNT_W{1'b0}};
            cnt_next_s = {CNT_W{1'b0}};
        end else begin
            acc_next_s = acc_out;
        end
    end

    // State and output registers; reset wins over any accept or handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            cnt_r     <= {CNT_W{1'b0}};
            acc_out   <= {ACC_W{1'b0}};
            sat_out   <= 1'b0;
            ovf_count <= {CNT_W{1'b0}};
            out_valid <= 1'b0;
        end else begin
            state_r   <= next_state_s;
            cnt_r     <= cnt_next_s;
            acc_out   <= acc_next_s;
            sat_out   <= sat_next_s;
            ovf_count <= ovf_next_s;
            out_valid <= (next_state_s == HOLD);
        end
    end

endmodule

// File: tb/tb_sum_accumulator.sv
// Self-checking bench: integer frame model checked every cycle, plus directed literal frames.
module tb_sum_accumulator;

    localparam int COUNT = 4;
    localparam int ACC_W = 6;
    localparam int CW    = $clog2(COUNT + 1);
    localparam int HI    = (1 << (ACC_W - 1)) - 1;
    localparam int LO    = -(1 << (ACC_W - 1));

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [4:0]    sum_in = 5'd0;
    logic          ovf_in = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [ACC_W-1:0] acc_out;
    logic          sat_out;
    logic [CW-1:0] ovf_count;

    int total = 0;
    int bad = 0;

    sum_accumulator #(.COUNT(COUNT), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .sum_in(sum_in), .ovf_in(ovf_in), .out_valid(out_valid),
        .out_ready(out_ready), .acc_out(acc_out), .sat_out(sat_out),
        .ovf_count(ovf_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int clampf(input int v);
        if (v > HI) return HI;
        if (v < LO) return LO;
        return v;
    endfunction

    // Frame model: running saturated sum, sticky flag, overflow tally, results taken.
    int m_acc = 0;
    int m_ovf = 0;
    int m_n   = 0;
    bit m_sat = 1'b0;
    bit m_hold = 1'b0;
    bit m_en = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_en <= 1'b1;
            m_acc <= 0; m_ovf <= 0; m_n <= 0; m_sat <= 1'b0; m_hold <= 1'b0;
        end else if (m_hold) begin
            if (out_ready) begin
                m_acc <= 0; m_ovf <= 0; m_n <= 0; m_sat <= 1'b0; m_hold <= 1'b0;
            end
        end else if (in_valid) begin
            m_acc <= clampf(m_acc + int'($signed(sum_in)));
            if (clampf(m_acc + int'($signed(sum_in))) != m_acc + int'($signed(sum_in)))
                m_sat <= 1'b1;
            m_ovf <= m_ovf + int'(ovf_in);
            m_n <= m_n + 1;
            if (m_n + 1 == COUNT) m_hold <= 1'b1;
        end
    end

    // Compare DUT against the model on the falling edge of every cycle.
    always @(negedge clk) begin
        if (m_en) begin
            chk("in_ready", int'(in_ready), int'(!m_hold));
            chk("out_valid", int'(out_valid), int'(m_hold));
            chk("acc_out", int'($signed(acc_out)), m_acc);
            chk("sat_out", int'(sat_out), int'(m_sat));
            chk("ovf_count", int'(ovf_count), m_ovf);
        end
    end

    task automatic send(input int s, input bit o, input int gap);
        int guard;
        repeat (gap) begin
            @(negedge clk);
            in_valid = 1'b0;
            sum_in = 5'($urandom);
        end
        @(negedge clk);
        in_valid = 1'b1;
        sum_in = s[4:0];
        ovf_in = o;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) chk("send_timeout", 0, 1);
    endtask

    task automatic expect_frame(input string name, input int acc, input bit sat,
                                input int ovf, input int stall);
        @(negedge clk);
        in_valid = 1'b0;
        chk({name, "_latency"}, int'(out_valid), 1);
        chk({name, "_acc"}, int'($signed(acc_out)), acc);
        chk({name, "_sat"}, int'(sat_out), int'(sat));
        chk({name, "_ovf"}, int'(ovf_count), ovf);
        repeat (stall) begin
            in_valid = 1'b1;
            sum_in = 5'd5;
            ovf_in = 1'b1;
            @(negedge clk);
            chk({name, "_stall_valid"}, int'(out_valid), 1);
            chk({name, "_stall_ready"}, int'(in_ready), 0);
            chk({name, "_stall_acc"}, int'($signed(acc_out)), acc);
            chk({name, "_stall_ovf"}, int'(ovf_count), ovf);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({name, "_rel_valid"}, int'(out_valid), 0);
        chk({name, "_rel_acc"}, int'($signed(acc_out)), 0);
        chk({name, "_rel_ovf"}, int'(ovf_count), 0);
        chk({name, "_rel_ready"}, int'(in_ready), 1);
    endtask

    initial begin
        int g7[4];
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_ready", int'(in_ready), 1);
        chk("reset_valid", int'(out_valid), 0);
        chk("reset_acc", int'(acc_out), 0);

        send(7, 1'b0, 0); send(9, 1'b0, 0); send(-9, 1'b0, 0); send(-1, 1'b0, 0);
        expect_frame("basic", 6, 1'b0, 0, 0);

        send(15, 1'b0, 0); send(15, 1'b0, 0); send(15, 1'b0, 0); send(-16, 1'b0, 0);
        expect_frame("sat_pos", 15, 1'b1, 0, 0);

        repeat (4) send(-16, 1'b0, 0);
        expect_frame("sat_neg", -32, 1'b1, 0, 3);

        send(3, 1'b1, 0); send(-2, 1'b0, 0); send(4, 1'b1, 0); send(1, 1'b1, 0);
        expect_frame("ovf", 6, 1'b0, 3, 0);

        send(1, 1'b0, 0); send(1, 1'b0, 0);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_acc", int'(acc_out), 0);
        chk("midrst_valid", int'(out_valid), 0);
        repeat (3) begin
            @(negedge clk);
            chk("midrst_novalid", int'(out_valid), 0);
        end
        repeat (4) send(1, 1'b0, 0);
        expect_frame("after_rst", 4, 1'b0, 0, 0);

        for (int i = 0; i < 4; i++) g7[i] = int'($urandom_range(0, 4));
        send(7, 1'b0, g7[0]); send(9, 1'b0, g7[1]); send(-9, 1'b0, g7[2]); send(-1, 1'b0, g7[3]);
        expect_frame("gapped", 6, 1'b0, 0, 0);

        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            in_valid  = ($urandom_range(0, 3) != 0);
            sum_in    = 5'($urandom);
            ovf_in    = 1'($urandom);
            out_ready = ($urandom_range(0, 2) == 0);
            rst       = ($urandom_range(0, 150) == 0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b0;
        rst = 1'b0;
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sum_accumulator.md
SUM_ACCUMULATOR -- requirements
Module: sum_accumulator

Interface
REQ-001 Parameter: COUNT, default 4, number of adder results accumulated per frame (legal range 2..8).
REQ-002 Parameter: ACC_W, default 6, accumulator width in bits, two's complement (legal range 6..16).
REQ-003 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: in_valid  input  1  an adder result is present on sum_in/ovf_in.
REQ-006 Port: in_ready  output  1  block accepts a result this cycle.
REQ-007 Port: sum_in  input  5  signed SUM from the 4-bit signed adder.
REQ-008 Port: ovf_in  input  1  overflow flag from the adder for the same result.
REQ-009 Port: out_valid  output  1  frame result is available.
REQ-010 Port: out_ready  input  1  downstream accepts the frame result.
REQ-011 Port: acc_out  output  ACC_W  signed, saturated sum of the frame's results.
REQ-012 Port: sat_out  output  1  sticky flag; saturation occurred during the frame.
REQ-013 Port: ovf_count  output  clog2(COUNT+1)  number of accepted results in the frame with ovf_in=1.

Function
REQ-014 Accept event SHALL be in_valid && in_ready sampled at a rising clk edge; no other condition modifies the accumulator.
REQ-015 FSM states SHALL be IDLE (no results in frame), ACCUM (1..COUNT-1 results accepted) and HOLD (frame complete, result presented).
REQ-016 in_ready SHALL be 1 in IDLE and ACCUM and 0 in HOLD; it is a function of the state register only.
REQ-017 On accept, acc SHALL become sat(acc + sign_extend(sum_in)), clamped to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
REQ-018 On an accept that clamps, sat_out SHALL set and stay set until the frame is cleared.
REQ-019 On accept with ovf_in=1, ovf_count SHALL increment by 1.
REQ-020 Transitions: IDLE->ACCUM on accept; ACCUM->ACCUM on accept with sample index < COUNT-1; ACCUM->HOLD on the COUNT-th accept.
REQ-021 out_valid SHALL be 1 exactly while in HOLD; it is registered and rises the cycle after the COUNT-th accept (latency 1 cycle).
REQ-022 In HOLD, acc_out, sat_out and ovf_count SHALL stay stable until out_valid && out_ready.
REQ-023 On out_valid && out_ready, the next state SHALL be IDLE, with acc, sat_out, ovf_count and the sample counter cleared to 0.
REQ-024 The cycle of the output handshake SHALL NOT also accept an input (in_ready=0); the earliest next accept is the following cycle.
REQ-025 out_ready outside HOLD SHALL have no effect; in_valid in HOLD SHALL have no effect.
REQ-026 acc_out, sat_out and ovf_count SHALL reflect the running values in IDLE and ACCUM; they are only guaranteed meaningful while out_valid=1.

Reset
REQ-027 While rst=1 at a clock edge, state SHALL become IDLE and acc_out, sat_out, ovf_count, out_valid and the sample counter SHALL become 0. in_ready reads 1 from the cycle after reset.
REQ-028 A reset in ACCUM or HOLD SHALL discard the partial or pending frame, with no out_valid pulse produced for it.
REQ-029 rst SHALL take priority over any simultaneous accept or output handshake.

Structure
REQ-030 A shared package adder_pkg SHALL hold SUM_W=5 and the FSM state enumeration (IDLE, ACCUM, HOLD).
REQ-031 A combinational sub-module sat_add (ACC_W-bit signed + SUM_W-bit signed -> ACC_W-bit saturated result plus a clamp flag) SHALL implement REQ-017.

Verification
REQ-032 Basic frame: defaults, sum_in 7, 9, -9, -1 with ovf_in 0, in_valid held high -> out_valid one cycle after the 4th accept; acc_out=6, sat_out=0, ovf_count=0.
REQ-033 Saturation: sum_in 15, 15, 15, -16 -> acc steps 15, 30, 31 (clamped), 15; final acc_out=15, sat_out=1. Negative case: sum_in -16 x4 -> acc_out=-32, sat_out=1.
REQ-034 Overflow count: ovf_in pattern 1, 0, 1, 1 with any sums -> ovf_count=3.
REQ-035 Backpressure: out_ready low for 3 cycles in HOLD -> outputs stable, in_ready=0, in_valid ignored. Raising out_ready -> IDLE next cycle with all outputs 0; the next frame then accepts normally.
REQ-036 Reset mid-frame: rst pulsed after 2 accepts -> all outputs 0, no out_valid. A following 4-sample frame (1, 1, 1, 1) -> acc_out=4.
REQ-037 Gapped input: in_valid deasserted between samples for random gaps -> result identical to the gap-free run of REQ-032.
